// File: rtl/ps_pkg.sv
// Shared types and widths for the program-sequencer loop controller.
// Address/count widths and the default stack depth live here so stack and controller agree.
package ps_pkg;

  localparam int ADDR_W       = 16;
  localparam int CNT_W        = 16;
  localparam int LP_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] start_add;
    logic [ADDR_W-1:0] end_add;
    logic [CNT_W-1:0]  cnt;
  } lp_entry_t;

  function automatic int dpth_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ps_loop_ctrl_if.sv
// Sequencer <-> loop controller signal bundle.
// slave = loop controller side, master = sequencer/decoder side.
interface ps_loop_ctrl_if
  import ps_pkg::*;
#(
  parameter int LP_DEPTH = LP_DEPTH_DEF
);

  logic                        lp_stall;
  logic                        lp_flush;
  logic                        lp_push;
  logic                        lp_pop;
  logic [ADDR_W-1:0]           lp_strt_add;
  logic [ADDR_W-1:0]           lp_end_add;
  logic [CNT_W-1:0]            lp_cnt_in;
  logic [ADDR_W-1:0]           fch_add;
  logic                        lp_jmp;
  logic [ADDR_W-1:0]           lp_jmp_add;
  logic [CNT_W-1:0]            lp_cnt_cur;
  logic                        lp_empty;
  logic                        lp_full;
  logic                        lp_ovf;
  logic [dpth_w(LP_DEPTH)-1:0] lp_dpth;

  modport slave (
    input  lp_stall, lp_flush, lp_push, lp_pop,
    input  lp_strt_add, lp_end_add, lp_cnt_in, fch_add,
    output lp_jmp, lp_jmp_add, lp_cnt_cur,
    output lp_empty, lp_full, lp_ovf, lp_dpth
  );

  modport master (
    output lp_stall, lp_flush, lp_push, lp_pop,
    output lp_strt_add, lp_end_add, lp_cnt_in, fch_add,
    input  lp_jmp, lp_jmp_add, lp_cnt_cur,
    input  lp_empty, lp_full, lp_ovf, lp_dpth
  );

endinterface

// File: rtl/lp_stack.sv
// LIFO of loop entries: clear, pop, top-count rewrite and push, applied in that order.
// Callers must not pop when empty nor push when the post-pop depth is full.
module lp_stack
  import ps_pkg::*;
#(
  parameter int LP_DEPTH = LP_DEPTH_DEF,
  localparam int PW = $clog2(LP_DEPTH),
  localparam int DW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             pop_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] dec_cnt_i,
  input  logic             push_i,
  input  lp_entry_t        push_ent_i,
  output lp_entry_t        top_o,
  output logic [DW-1:0]    depth_o,
  output logic             full_o,
  output logic             empty_o
);

  lp_entry_t     mem_q [LP_DEPTH];
  logic [DW-1:0] depth_q;
  logic [DW-1:0] depth_d;
  logic [DW-1:0] base;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] push_idx;

  // base is the depth after clear/pop; a same-cycle push lands right there
  assign base     = clr_i ? '0 : (depth_q - DW'(pop_i));
  assign depth_d  = base + DW'(push_i);
  assign top_idx  = PW'(depth_q - DW'(1));
  assign push_idx = PW'(base);

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == DW'(LP_DEPTH));
  assign depth_o = depth_q;
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      for (int i = 0; i < LP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      depth_q <= depth_d;
      if (dec_i && !clr_i && !pop_i) begin
        mem_q[top_idx].cnt <= dec_cnt_i;
      end
      if (push_i) begin
        mem_q[push_idx] <= push_ent_i;
      end
    end
  end

endmodule

// File: rtl/ps_loop_ctrl.sv
// Zero-overhead loop controller: end-address compare, redirect, count and stack priority.
// Optional LP_ZERO_SKIP_EN: a DO with count 0 skips the body instead of running 2^CNT_W times.
module ps_loop_ctrl
  import ps_pkg::*;
#(
  parameter int LP_DEPTH = LP_DEPTH_DEF,
  localparam int DW = $clog2(LP_DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  ps_loop_ctrl_if.slave lp
);

  lp_entry_t     top_ent;
  lp_entry_t     push_ent;
  logic [DW-1:0] depth;
  logic [DW-1:0] depth_after;
  logic          empty;
  logic          full;
  logic          term;
  logic          last;
  logic          do_pop;
  logic          term_pop;
  logic          term_dec;
  logic          jmp_term;
  logic          skip_req;
  logic          skip_jmp;
  logic          push_req;
  logic          push_ok;
  logic          ovf_q;
  logic          ovf_d;

  assign term = !lp.lp_stall && !empty && (lp.fch_add == top_ent.end_add);
  assign last = (top_ent.cnt == CNT_W'(1));

  // flush > explicit pop > termination; push is applied on top of the result
  assign do_pop   = !lp.lp_flush && lp.lp_pop && !empty;
  assign term_pop = !lp.lp_flush && !lp.lp_pop && term && last;
  assign term_dec = !lp.lp_flush && !lp.lp_pop && term && !last;
  assign jmp_term = term_dec;

`ifdef LP_ZERO_SKIP_EN
  assign skip_req = lp.lp_push && (lp.lp_cnt_in == '0);
  assign skip_jmp = skip_req && !lp.lp_flush;
`else
  assign skip_req = 1'b0;
  assign skip_jmp = 1'b0;
`endif

  assign depth_after = lp.lp_flush ? '0 : (depth - DW'(do_pop || term_pop));
  assign push_req    = lp.lp_push && !skip_req;
  assign push_ok     = push_req && (depth_after != DW'(LP_DEPTH));
  assign ovf_d       = ovf_q || (push_req && !push_ok);

  assign push_ent.start_add = lp.lp_strt_add;
  assign push_ent.end_add   = lp.lp_end_add;
  assign push_ent.cnt       = lp.lp_cnt_in;

  lp_stack #(
    .LP_DEPTH (LP_DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (lp.lp_flush),
    .pop_i      (do_pop || term_pop),
    .dec_i      (term_dec),
    .dec_cnt_i  (top_ent.cnt - CNT_W'(1)),
    .push_i     (push_ok),
    .push_ent_i (push_ent),
    .top_o      (top_ent),
    .depth_o    (depth),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // a term redirect takes precedence over a zero-count skip in the same cycle
  assign lp.lp_jmp     = jmp_term || skip_jmp;
  assign lp.lp_jmp_add = jmp_term ? top_ent.start_add :
                         skip_jmp ? (lp.lp_end_add + ADDR_W'(1)) : '0;
  assign lp.lp_cnt_cur = top_ent.cnt;
  assign lp.lp_empty   = empty;
  assign lp.lp_full    = full;
  assign lp.lp_ovf     = ovf_q;
  assign lp.lp_dpth    = depth;

endmodule

// File: doc/ps_loop_ctrl.md
Name: ps_loop_ctrl

Overview:
- Hardware zero-overhead loop controller for the program sequencer; executes nested DO <addr> UNTIL LCE loops.
- Holds a LIFO loop stack of start address, end address and iteration count for each loop.
- Compares every fetch address against the top loop's end address, issues the redirect back to the loop start, decrements the count, and pops the entry on the final pass.
- Sits beside the fetch-address register. lp_jmp/lp_jmp_add feed the fetch-address mux alongside jump and return.

Parameters:
- LP_DEPTH, 4, loop stack entries (power of two, >=2).
- ADDR_W, 16, program address width.
- CNT_W, 16, loop counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- lp_stall  in  1  sequencer idle/stall. Freezes termination detection and counter update.
- lp_flush  in  1  abort all loops (interrupt/branch-out). Empties the stack.
- lp_push  in  1  decoded DO UNTIL instruction, valid this cycle.
- lp_pop  in  1  decoded explicit POP LOOP instruction.
- lp_strt_add  in  ADDR_W  first address of the loop body.
- lp_end_add  in  ADDR_W  last address of the loop body.
- lp_cnt_in  in  CNT_W  iteration count for the pushed loop.
- fch_add  in  ADDR_W  current fetch address.
- lp_jmp  out  1  redirect fetch to lp_jmp_add next cycle (combinational).
- lp_jmp_add  out  ADDR_W  redirect target (combinational).
- lp_cnt_cur  out  CNT_W  top-of-stack count (CURLCNTR readback); 0 when the stack is empty.
- lp_empty  out  1  stack empty.
- lp_full  out  1  stack full.
- lp_ovf  out  1  sticky overflow: push attempted while full.
- lp_dpth  out  $clog2(LP_DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst=1 at posedge):
  - pointer=0, lp_empty=1, lp_full=0, lp_ovf=0, lp_dpth=0.
  - Entry contents cleared to 0.
  - Hence lp_jmp=0, lp_jmp_add=0, lp_cnt_cur=0.
  - Reset mid-loop discards all loops with no redirect.
- Termination hit: term = !lp_stall & !lp_empty & (fch_add == top.end).
- lp_jmp = term & (top.cnt != 1) & !lp_pop & !lp_flush. lp_jmp_add = top.start when lp_jmp, else 0.
- On a term cycle where top.cnt != 1 and there is no pop/flush, top.cnt <= top.cnt-1.
- If top.cnt == 1 on a term cycle, the entry pops; no jump; fetch falls through to end+1.
- Count 0 (feature off) means 2^CNT_W iterations: it decrements 0 to FFFF and proceeds normally.
- Update priority per cycle, highest first:
  - flush: empty the stack.
  - pop: remove the top entry, no jump.
  - term: decrement or pop the top entry.
  - push: apply after the above. A push in the same cycle as a term-pop or explicit pop reuses the freed slot.
- lp_stall=1 suppresses term, decrement and pop-by-term.
  - Explicit push, pop and flush are still honoured; the decoder gates them.
- Push while full (after same-cycle pops):
  - Push is ignored and the stack is unchanged.
  - lp_ovf <= 1 and stays set until rst.
- Pop while empty: ignored, no flag.
- Nested loops sharing an end address:
  - Only the top entry is compared.
  - When the inner loop pops, the outer loop is compared from the next cycle onward.
- Latency:
  - lp_jmp is valid in the same cycle as fch_add.
  - The sequencer loads lp_jmp_add into the fetch address at the next posedge.
  - Stack state updates at that same posedge.
- lp_full = (lp_dpth == LP_DEPTH). lp_empty = (lp_dpth == 0).

Optional Feature:
- Macro LP_ZERO_SKIP_EN.
- Defined: a push with lp_cnt_in==0 does not push an entry. Instead:
  - lp_jmp=1 and lp_jmp_add=lp_end_add+1 in the same cycle, so the body is skipped.
  - This redirect is suppressed by flush.
  - If term also asserts lp_jmp in that cycle, the term redirect wins; the skip still takes effect and no push occurs.
- Undefined: count 0 means 2^CNT_W iterations, as above.

Decomposition:
- Shared package ps_pkg:
  - ADDR_W and CNT_W constants.
  - lp_entry_t struct {start, end, cnt}.
  - LP_DEPTH default.
- Sub-module lp_stack:
  - LIFO storage with push, pop, top-count write, top read, depth, full and empty.
  - The parent holds the term compare, priority logic, redirect and overflow flag.

Test Plan:
- Push start=0x0010, end=0x0013, cnt=3, then fetch walks 0x10..0x13:
  - lp_jmp=1 to 0x0010 on the first two hits at 0x13; lp_cnt_cur goes 3, 2, 1.
  - On the third hit: no jump, pop, lp_empty=1.
- Nested loops: outer {0x20,0x28,2}, inner {0x22,0x24,2} → 0x22..0x24 executes twice per outer pass, 4 times total; the outer redirect to 0x20 occurs exactly once; the stack ends empty.
- Push 5 entries with LP_DEPTH=4 → the 5th is ignored; lp_full=1, lp_ovf=1; lp_ovf stays 1 after 4 pops and clears only on rst.
- At fch_add=end with cnt=2, assert lp_stall → no jump, cnt unchanged. Release lp_stall → jump taken, cnt=1.
- Simultaneous cases:
  - lp_pop with term: no jump, one entry removed.
  - lp_flush with term: no jump, stack emptied.
  - term-pop with a push (cnt=1): the new entry occupies the freed slot and lp_dpth is unchanged.
- With LP_ZERO_SKIP_EN: push {0x40,0x45,0} → lp_jmp=1, lp_jmp_add=0x0046, lp_dpth unchanged. Without the macro: 65536 iterations; check the first FFFF decrement.
